// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS CPU memory-bus arbiter.
//   arb_state_t : arbiter state (idle, or granted to master 0 / master 1)
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  // Number of masters sharing the slave bus.
  localparam int unsigned ArbNumMasters = 2;

endpackage

// File: rtl/mips_cpu_rr_picker.sv
// Two-way round-robin picker, purely combinational.
// Ports:
//   i_req   [1:0] request per master
//   i_last        master that completed the most recent transfer
//   o_pick        chosen master index (meaningful only when o_valid=1)
//   o_valid       at least one master is requesting
module mips_cpu_rr_picker (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_pick,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    // On a tie the master that did not go last wins; otherwise the lone requester.
    if (&i_req) begin
      o_pick = ~i_last;
    end else begin
      o_pick = i_req[1];
    end
  end

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// Two-master to one-slave Avalon-MM arbiter for the CPU memory bus.
// Master 0 is instruction fetch, master 1 is data load/store (or debug/DMA).
// A grant is registered and held until the granted master's transfer completes;
// contention is resolved round-robin. The slave bus is quiet while nothing is granted.
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_m{0,1}_address/read/write/
//     writedata/byteenable          master requests
//   o_m{0,1}_waitrequest/readdata   master responses
//   o_s_address/read/write/
//     writedata/byteenable          slave request
//   i_s_waitrequest, i_s_readdata   slave response
module mips_cpu_bus_arbiter
  import mips_cpu_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned FIRST_WIN = 0
) (
  input  logic            i_clk,
  input  logic            i_reset,

  input  logic [AW-1:0]   i_m0_address,
  input  logic            i_m0_read,
  input  logic            i_m0_write,
  input  logic [DW-1:0]   i_m0_writedata,
  input  logic [DW/8-1:0] i_m0_byteenable,
  output logic            o_m0_waitrequest,
  output logic [DW-1:0]   o_m0_readdata,

  input  logic [AW-1:0]   i_m1_address,
  input  logic            i_m1_read,
  input  logic            i_m1_write,
  input  logic [DW-1:0]   i_m1_writedata,
  input  logic [DW/8-1:0] i_m1_byteenable,
  output logic            o_m1_waitrequest,
  output logic [DW-1:0]   o_m1_readdata,

  output logic [AW-1:0]   o_s_address,
  output logic            o_s_read,
  output logic            o_s_write,
  output logic [DW-1:0]   o_s_writedata,
  output logic [DW/8-1:0] o_s_byteenable,
  input  logic            i_s_waitrequest,
  input  logic [DW-1:0]   i_s_readdata
);

  // 'last' resets to the loser of the first tie so FIRST_WIN takes the first one.
  localparam logic LastRst = (FIRST_WIN == 0) ? 1'b1 : 1'b0;

  arb_state_t r_state;
  logic       r_last;

  logic w_req0;
  logic w_req1;
  logic w_pick;
  logic w_valid;

  assign w_req0 = i_m0_read | i_m0_write;
  assign w_req1 = i_m1_read | i_m1_write;

  mips_cpu_rr_picker u_picker (
    .i_req   ({w_req1, w_req0}),
    .i_last  (r_last),
    .o_pick  (w_pick),
    .o_valid (w_valid)
  );

  // Grant FSM. A done hands straight over to a waiting peer (no bubble); a master
  // re-requesting after its own done goes back through IDLE. Dropping the request
  // while granted is an abort: release the bus without touching 'last'.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ARB_IDLE;
      r_last  <= LastRst;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_valid) begin
            r_state <= w_pick ? ARB_GNT1 : ARB_GNT0;
          end
        end
        ARB_GNT0: begin
          if (!w_req0) begin
            r_state <= ARB_IDLE;
          end else if (!i_s_waitrequest) begin
            r_last  <= 1'b0;
            r_state <= w_req1 ? ARB_GNT1 : ARB_IDLE;
          end
        end
        ARB_GNT1: begin
          if (!w_req1) begin
            r_state <= ARB_IDLE;
          end else if (!i_s_waitrequest) begin
            r_last  <= 1'b1;
            r_state <= w_req0 ? ARB_GNT0 : ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // Output muxes. An ungranted master is stalled exactly while it requests, so an
  // idle master never sees waitrequest. Reset forces the slave quiet immediately.
  always_comb begin
    o_s_address      = '0;
    o_s_read         = 1'b0;
    o_s_write        = 1'b0;
    o_s_writedata    = '0;
    o_s_byteenable   = '0;
    o_m0_waitrequest = w_req0;
    o_m1_waitrequest = w_req1;
    if (i_reset) begin
      o_m0_waitrequest = 1'b0;
      o_m1_waitrequest = 1'b0;
    end else begin
      case (r_state)
        ARB_GNT0: begin
          o_s_address      = i_m0_address;
          o_s_read         = i_m0_read;
          o_s_write        = i_m0_write;
          o_s_writedata    = i_m0_writedata;
          o_s_byteenable   = i_m0_byteenable;
          o_m0_waitrequest = i_s_waitrequest;
        end
        ARB_GNT1: begin
          o_s_address      = i_m1_address;
          o_s_read         = i_m1_read;
          o_s_write        = i_m1_write;
          o_s_writedata    = i_m1_writedata;
          o_s_byteenable   = i_m1_byteenable;
          o_m1_waitrequest = i_s_waitrequest;
        end
        default: ;
      endcase
    end
  end

  // Read data fans out; each master qualifies it with its own handshake.
  assign o_m0_readdata = i_s_readdata;
  assign o_m1_readdata = i_s_readdata;

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
module tb_mips_cpu_bus_arbiter;
  import mips_cpu_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk;
  logic            i_reset;
  logic [AW-1:0]   i_m0_address,   i_m1_address;
  logic            i_m0_read,      i_m1_read;
  logic            i_m0_write,     i_m1_write;
  logic [DW-1:0]   i_m0_writedata, i_m1_writedata;
  logic [DW/8-1:0] i_m0_byteenable, i_m1_byteenable;
  logic            o_m0_waitrequest, o_m1_waitrequest;
  logic [DW-1:0]   o_m0_readdata,  o_m1_readdata;
  logic [AW-1:0]   o_s_address;
  logic            o_s_read, o_s_write;
  logic [DW-1:0]   o_s_writedata;
  logic [DW/8-1:0] o_s_byteenable;
  logic            i_s_waitrequest;
  logic [DW-1:0]   i_s_readdata;

  int n_vec = 0;
  int n_err = 0;

  mips_cpu_bus_arbiter #(
    .AW        (AW),
    .DW        (DW),
    .FIRST_WIN (0)
  ) dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .i_m0_address     (i_m0_address),
    .i_m0_read        (i_m0_read),
    .i_m0_write       (i_m0_write),
    .i_m0_writedata   (i_m0_writedata),
    .i_m0_byteenable  (i_m0_byteenable),
    .o_m0_waitrequest (o_m0_waitrequest),
    .o_m0_readdata    (o_m0_readdata),
    .i_m1_address     (i_m1_address),
    .i_m1_read        (i_m1_read),
    .i_m1_write       (i_m1_write),
    .i_m1_writedata   (i_m1_writedata),
    .i_m1_byteenable  (i_m1_byteenable),
    .o_m1_waitrequest (o_m1_waitrequest),
    .o_m1_readdata    (o_m1_readdata),
    .o_s_address      (o_s_address),
    .o_s_read         (o_s_read),
    .o_s_write        (o_s_write),
    .o_s_writedata    (o_s_writedata),
    .o_s_byteenable   (o_s_byteenable),
    .i_s_waitrequest  (i_s_waitrequest),
    .i_s_readdata     (i_s_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    i_m0_address = '0; i_m0_read = 0; i_m0_write = 0; i_m0_writedata = '0; i_m0_byteenable = '0;
    i_m1_address = '0; i_m1_read = 0; i_m1_write = 0; i_m1_writedata = '0; i_m1_byteenable = '0;
    i_s_waitrequest = 0; i_s_readdata = '0;

    // Reset held two cycles with m0 requesting
    i_reset = 1; i_m0_read = 1; i_m0_address = 32'h0040_0000;
    #2;
    chk("rst_c1_s_read", o_s_read, 0);
    chk("rst_c1_m0_wait", o_m0_waitrequest, 0);
    step(); #1;
    chk("rst_c2_s_read", o_s_read, 0);
    chk("rst_c2_m0_wait", o_m0_waitrequest, 0);
    step();
    i_reset = 0; i_m0_read = 0; #1;
    chk("rst_state_idle", dut.r_state, ARB_IDLE);
    chk("rst_idle_m0_wait", o_m0_waitrequest, 0);

    // Single read from m0
    i_m0_read = 1; i_m0_address = 32'h0040_0000; i_s_readdata = 32'h8C02_0004; #1;
    chk("rd_arb_s_read", o_s_read, 0);
    chk("rd_arb_m0_wait", o_m0_waitrequest, 1);
    step(); #1;
    chk("rd_s_read", o_s_read, 1);
    chk("rd_s_addr", o_s_address, 32'h0040_0000);
    chk("rd_m0_wait", o_m0_waitrequest, 0);
    chk("rd_m0_rdata", o_m0_readdata, 32'h8C02_0004);
    step();
    i_m0_read = 0; #1;
    chk("rd_after_idle", dut.r_state, ARB_IDLE);
    chk("rd_after_s_read", o_s_read, 0);

    // Re-reset so the tie goes to FIRST_WIN=0
    i_reset = 1; step(); i_reset = 0;

    // Contention: m0 read vs m1 write, then a 3-cycle slave stall on m1's write
    i_m0_read = 1; i_m0_address = 32'h0040_0010;
    i_m1_write = 1; i_m1_address = 32'h0000_1000;
    i_m1_writedata = 32'hDEAD_BEEF; i_m1_byteenable = 4'b1111; #1;
    chk("ct_arb_m0_wait", o_m0_waitrequest, 1);
    chk("ct_arb_m1_wait", o_m1_waitrequest, 1);
    chk("ct_arb_s_rw", {o_s_read, o_s_write}, 2'b00);
    step(); #1;
    chk("ct_g0_s_read", o_s_read, 1);
    chk("ct_g0_s_addr", o_s_address, 32'h0040_0010);
    chk("ct_g0_m0_wait", o_m0_waitrequest, 0);
    chk("ct_g0_m1_wait", o_m1_waitrequest, 1);
    step();
    i_m0_read = 0; i_s_waitrequest = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("st_s_write", o_s_write, 1);
      chk("st_s_addr", o_s_address, 32'h0000_1000);
      chk("st_s_wdata", o_s_writedata, 32'hDEAD_BEEF);
      chk("st_s_be", o_s_byteenable, 4'b1111);
      chk("st_m1_wait", o_m1_waitrequest, 1);
      chk("st_m0_wait", o_m0_waitrequest, 0);
      step();
    end
    i_s_waitrequest = 0; #1;
    chk("st_done_s_write", o_s_write, 1);
    chk("st_done_m1_wait", o_m1_waitrequest, 0);
    step();
    i_m1_write = 0; #1;
    chk("st_after_idle", dut.r_state, ARB_IDLE);

    // Fairness: both read continuously; last=1 so m0 first, then alternate
    i_m0_read = 1; i_m0_address = 32'h0000_00A0;
    i_m1_read = 1; i_m1_address = 32'h0000_00B0;
    i_s_readdata = 32'h1234_5678; #1;
    chk("fr_arb_s_read", o_s_read, 0);
    step();
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("fr_s_addr", o_s_address, (k % 2 == 0) ? 64'hA0 : 64'hB0);
      chk("fr_waits", {o_m0_waitrequest, o_m1_waitrequest}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k == 1) chk("fr_m1_rdata", o_m1_readdata, 32'h1234_5678);
      step();
    end
    i_m0_read = 0; i_m1_read = 0;
    step(); #1;
    chk("fr_after_idle", dut.r_state, ARB_IDLE);

    // Abort: m1 drops its write while granted and stalled
    i_m1_write = 1; i_m1_address = 32'h0000_2000; i_s_waitrequest = 1;
    step(); #1;
    chk("ab_s_write", o_s_write, 1);
    chk("ab_m1_wait", o_m1_waitrequest, 1);
    i_m1_write = 0;
    step(); #1;
    chk("ab_state_idle", dut.r_state, ARB_IDLE);
    chk("ab_s_write_off", o_s_write, 0);

    // Reset during a stalled GNT0 read
    i_m0_read = 1; i_m0_address = 32'h0040_0020;
    step(); #1;
    chk("rm_s_read", o_s_read, 1);
    i_reset = 1; #1;
    chk("rm_rst_s_read", o_s_read, 0);
    chk("rm_rst_m0_wait", o_m0_waitrequest, 0);
    step();
    i_reset = 0; i_m0_read = 0; i_s_waitrequest = 0; #1;
    chk("rm_state_idle", dut.r_state, ARB_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
